// File: rtl/equeueint_if.sv
// rtl/equeueint_if.sv - dispatch, CDB and issue signal bundle for the integer issue queue
//
// Groups every handshake/bus signal of equeueint.
//   slave  : the queue itself (takes dispatch/CDB/issueint_done, drives ready and issue outputs)
//   master : the surrounding pipeline (drives dispatch/CDB/issueint_done)
interface equeueint_if;
  logic [3:0]  dispatch_opcode;
  logic        dispatch_en;
  logic        dispatch_ready;
  logic [5:0]  dispatch_rdtag;
  logic [5:0]  dispatch_rstag;
  logic [5:0]  dispatch_rttag;
  logic [31:0] dispatch_rsdata;
  logic [31:0] dispatch_rtdata;
  logic        dispatch_rsvalid;
  logic        dispatch_rtvalid;

  logic [5:0]  cdb_tag;
  logic        cdb_valid;
  logic [31:0] cdb_data;

  logic [3:0]  issueint_opcode;
  logic [5:0]  issueint_rdtag;
  logic [31:0] issueint_rsdata;
  logic [31:0] issueint_rtdata;
  logic        issueint_ready;
  logic        issueint_done;

  modport master (
    output dispatch_opcode, dispatch_en, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
           cdb_tag, cdb_valid, cdb_data, issueint_done,
    input  dispatch_ready, issueint_opcode, issueint_rdtag, issueint_rsdata,
           issueint_rtdata, issueint_ready
  );

  modport slave (
    input  dispatch_opcode, dispatch_en, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
           cdb_tag, cdb_valid, cdb_data, issueint_done,
    output dispatch_ready, issueint_opcode, issueint_rdtag, issueint_rsdata,
           issueint_rtdata, issueint_ready
  );
endinterface

// File: rtl/equeueint.sv
// rtl/equeueint.sv - age-ordered integer issue queue with CDB operand capture
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high reset, clears every entry immediately
//   eq    : equeueint_if.slave (dispatch in, CDB in, issue out, issueint_done in)
// Parameter DEPTH (2..16): number of entries.
// Optional feature: define EQUEUEINT_CDB_BYPASS_EN to let a dispatched operand pick up
// a same-cycle CDB broadcast of its tag; undefined, it waits for a later broadcast.
module equeueint #(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  equeueint_if.slave eq
);

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [5:0]  rdtag;
    logic [5:0]  rstag;
    logic [5:0]  rttag;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic        rsvalid;
    logic        rtvalid;
  } entry_t;

  entry_t q_r [DEPTH];
  entry_t q_n [DEPTH];
  entry_t ext [DEPTH+1];
  entry_t new_e;

  logic [4:0]  count;
  logic [4:0]  free_pos;
  logic [4:0]  sel_pos;
  logic        sel_found;
  logic        issue;
  logic        disp_acc;
  logic [3:0]  out_opcode;
  logic [5:0]  out_rdtag;
  logic [31:0] out_rsdata;
  logic [31:0] out_rtdata;

  // Valid entries are contiguous from 0, so the top slot alone tells us if we are full.
  assign eq.dispatch_ready  = ~q_r[DEPTH-1].valid;
  assign eq.issueint_ready  = sel_found;
  assign eq.issueint_opcode = out_opcode;
  assign eq.issueint_rdtag  = out_rdtag;
  assign eq.issueint_rsdata = out_rsdata;
  assign eq.issueint_rtdata = out_rtdata;

  assign issue    = eq.issueint_done & sel_found;
  assign disp_acc = eq.dispatch_en & ~q_r[DEPTH-1].valid;
  assign free_pos = count - {4'b0, issue};

  // Occupancy and oldest-ready selection, purely from registered state.
  always_comb begin
    count      = '0;
    sel_found  = 1'b0;
    sel_pos    = '0;
    out_opcode = '0;
    out_rdtag  = '0;
    out_rsdata = '0;
    out_rtdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + 5'(q_r[i].valid);
    end
    // Scan youngest to oldest so the last hit is the oldest ready entry.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q_r[i].valid && q_r[i].rsvalid && q_r[i].rtvalid) begin
        sel_found  = 1'b1;
        sel_pos    = 5'(i);
        out_opcode = q_r[i].opcode;
        out_rdtag  = q_r[i].rdtag;
        out_rsdata = q_r[i].rsdata;
        out_rtdata = q_r[i].rtdata;
      end
    end
  end

  // Incoming entry, optionally forwarding a same-cycle broadcast.
  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.opcode  = eq.dispatch_opcode;
    new_e.rdtag   = eq.dispatch_rdtag;
    new_e.rstag   = eq.dispatch_rstag;
    new_e.rttag   = eq.dispatch_rttag;
    new_e.rsdata  = eq.dispatch_rsdata;
    new_e.rtdata  = eq.dispatch_rtdata;
    new_e.rsvalid = eq.dispatch_rsvalid;
    new_e.rtvalid = eq.dispatch_rtvalid;
`ifdef EQUEUEINT_CDB_BYPASS_EN
    if (eq.cdb_valid && !eq.dispatch_rsvalid && eq.cdb_tag == eq.dispatch_rstag) begin
      new_e.rsdata  = eq.cdb_data;
      new_e.rsvalid = 1'b1;
    end
    if (eq.cdb_valid && !eq.dispatch_rtvalid && eq.cdb_tag == eq.dispatch_rttag) begin
      new_e.rtdata  = eq.cdb_data;
      new_e.rtvalid = 1'b1;
    end
`endif
  end

  // Next state: remove the issued entry (shift younger ones down), capture CDB into
  // the post-shift positions, then place the dispatch in the first free slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ext[i] = q_r[i];
    end
    ext[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && 5'(i) >= sel_pos) begin
        q_n[i] = ext[i+1];
      end else begin
        q_n[i] = ext[i];
      end
      if (eq.cdb_valid && q_n[i].valid) begin
        if (!q_n[i].rsvalid && q_n[i].rstag == eq.cdb_tag) begin
          q_n[i].rsdata  = eq.cdb_data;
          q_n[i].rsvalid = 1'b1;
        end
        if (!q_n[i].rtvalid && q_n[i].rttag == eq.cdb_tag) begin
          q_n[i].rtdata  = eq.cdb_data;
          q_n[i].rtvalid = 1'b1;
        end
      end
      if (disp_acc && 5'(i) == free_pos) begin
        q_n[i] = new_e;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= q_n[i];
      end
    end
  end

endmodule

// File: tb/tb_equeueint.sv
// tb/tb_equeueint.sv - self-checking bench for equeueint
module tb_equeueint;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  equeueint_if bus ();

  equeueint #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .eq    (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit en; logic [3:0] op; logic [5:0] rd, rs, rt; logic [31:0] rsd, rtd; bit rsv, rtv;
    bit cv; logic [5:0] ct; logic [31:0] cd; bit done;
    bit e_dr, e_ir; logic [3:0] e_op; logic [5:0] e_rd; logic [31:0] e_rsd;
  } vec_t;

  function automatic vec_t mkv(bit en, logic [3:0] op, logic [5:0] rd, logic [5:0] rs, logic [5:0] rt,
                               logic [31:0] rsd, logic [31:0] rtd, bit rsv, bit rtv,
                               bit cv, logic [5:0] ct, logic [31:0] cd, bit done,
                               bit e_dr, bit e_ir, logic [3:0] e_op, logic [5:0] e_rd, logic [31:0] e_rsd);
    vec_t v;
    v.en = en; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.rsd = rsd; v.rtd = rtd;
    v.rsv = rsv; v.rtv = rtv; v.cv = cv; v.ct = ct; v.cd = cd; v.done = done;
    v.e_dr = e_dr; v.e_ir = e_ir; v.e_op = e_op; v.e_rd = e_rd; v.e_rsd = e_rsd;
    return v;
  endfunction

  task automatic drive(input bit en, input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs,
                       input logic [5:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                       input bit rsv, input bit rtv, input bit cv, input logic [5:0] ct,
                       input logic [31:0] cd, input bit done);
    bus.dispatch_en = en; bus.dispatch_opcode = op; bus.dispatch_rdtag = rd;
    bus.dispatch_rstag = rs; bus.dispatch_rttag = rt; bus.dispatch_rsdata = rsd;
    bus.dispatch_rtdata = rtd; bus.dispatch_rsvalid = rsv; bus.dispatch_rtvalid = rtv;
    bus.cdb_valid = cv; bus.cdb_tag = ct; bus.cdb_data = cd; bus.issueint_done = done;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_out(input string n, input bit dr, input bit ir, input logic [3:0] op,
                         input logic [5:0] rd, input logic [31:0] rsd);
    chk({n, ".dispatch_ready"}, 32'(bus.dispatch_ready), 32'(dr));
    chk({n, ".issueint_ready"}, 32'(bus.issueint_ready), 32'(ir));
    chk({n, ".opcode"}, 32'(bus.issueint_opcode), 32'(op));
    chk({n, ".rdtag"}, 32'(bus.issueint_rdtag), 32'(rd));
    chk({n, ".rsdata"}, bus.issueint_rsdata, rsd);
  endtask

  // Reference model: an ordered list of waiting instructions.
  typedef struct { logic [3:0] op; logic [5:0] rd, rs, rt; logic [31:0] rsd, rtd; bit rsv, rtv; } m_t;
  m_t mq[$];

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++) if (mq[i].rsv && mq[i].rtv) return i;
    return -1;
  endfunction

  vec_t tbl[$];
  bit bypass;

  initial begin
`ifdef EQUEUEINT_CDB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    idle();
    #1;
    chk_out("reset_async", 1, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset_held", 1, 0, 0, 0, 0);
    reset = 1'b0;

    tbl.push_back(mkv(1, 0, 1, 2, 3, 2, 2, 1, 1, 0, 0, 0, 0,      1, 1, 0, 1, 2));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 3, 4, 5, 6, 0, 9, 0, 1, 0, 0, 0, 0,      1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 1, 1, 3, 4, 32'h1234));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 5, 10, 20, 21, 0, 1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 6, 11, 22, 23, 32'h55, 2, 1, 1, 0, 0, 0, 0, 1, 1, 6, 11, 32'h55));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 32'h77, 0, 1, 1, 5, 10, 32'h77));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0));
    if (bypass) begin
      tbl.push_back(mkv(1, 9, 12, 7, 8, 0, 3, 0, 1, 1, 7, 32'hAA, 0, 1, 1, 9, 12, 32'hAA));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hBB, 0,  1, 1, 9, 12, 32'hAA));
    end else begin
      tbl.push_back(mkv(1, 9, 12, 7, 8, 0, 3, 0, 1, 1, 7, 32'hAA, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hBB, 0,  1, 1, 9, 12, 32'hBB));
    end
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 13, 30, 31, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 2, 14, 32, 33, 32'h14, 0, 1, 1, 0, 0, 0, 0, 1, 1, 2, 14, 32'h14));
    tbl.push_back(mkv(1, 4, 15, 30, 34, 0, 0, 0, 1, 1, 30, 32'h99, 1, 1, 1, 1, 13, 32'h99));
    if (bypass) begin
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 1, 4, 15, 32'h99));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 32'h42, 0, 1, 1, 4, 15, 32'h99));
    end else begin
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0));
      tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 30, 32'h42, 0, 1, 1, 4, 15, 32'h42));
    end
    tbl.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,      1, 0, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].en, tbl[k].op, tbl[k].rd, tbl[k].rs, tbl[k].rt, tbl[k].rsd, tbl[k].rtd,
            tbl[k].rsv, tbl[k].rtv, tbl[k].cv, tbl[k].ct, tbl[k].cd, tbl[k].done);
      @(posedge clk);
      @(negedge clk);
      idle();
      chk_out($sformatf("vec%0d", k), tbl[k].e_dr, tbl[k].e_ir, tbl[k].e_op, tbl[k].e_rd, tbl[k].e_rsd);
    end

    // Fill to DEPTH, extra dispatch ignored, one done reopens the queue.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 4'(i), 6'(30 + i), 0, 0, 32'(i), 0, 1, 1, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    chk_out("full", 0, 1, 0, 30, 0);
    drive(1, 7, 50, 0, 0, 32'h50, 0, 1, 1, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    idle();
    chk_out("full_ignored", 0, 1, 0, 30, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      @(negedge clk);
      idle();
      if (i < DEPTH) chk_out($sformatf("drain%0d", i), 1, 1, 4'(i), 6'(30 + i), 32'(i));
      else           chk_out("drained", 1, 0, 0, 0, 0);
    end

    // Reset with three entries queued takes effect before the next edge.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 6'(40 + i), 0, 0, 1, 1, 1, 1, 0, 0, 0, 0);
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    chk_out("pre_reset", 1, 1, 1, 40, 1);
    reset = 1'b1;
    #1;
    chk_out("mid_reset", 1, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_out("post_reset", 1, 0, 0, 0, 0);

    // Randomised run against the list model.
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      int s;
      bit pre_ready;
      m_t ne;
      drive(1'($urandom_range(0, 1)), 4'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            6'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 2) != 0));
      #1;
      s = m_sel();
      pre_ready = (mq.size() < DEPTH);
      if (s >= 0) begin
        chk_out($sformatf("rnd%0d", cyc), pre_ready, 1, mq[s].op, mq[s].rd, mq[s].rsd);
        chk($sformatf("rnd%0d.rtdata", cyc), bus.issueint_rtdata, mq[s].rtd);
      end else begin
        chk_out($sformatf("rnd%0d", cyc), pre_ready, 0, 0, 0, 0);
      end
      ne.op = bus.dispatch_opcode; ne.rd = bus.dispatch_rdtag; ne.rs = bus.dispatch_rstag;
      ne.rt = bus.dispatch_rttag; ne.rsd = bus.dispatch_rsdata; ne.rtd = bus.dispatch_rtdata;
      ne.rsv = bus.dispatch_rsvalid; ne.rtv = bus.dispatch_rtvalid;
      @(posedge clk);
      if (bus.issueint_done && s >= 0) mq.delete(s);
      if (bus.cdb_valid) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].rsv && mq[i].rs == bus.cdb_tag) begin mq[i].rsv = 1; mq[i].rsd = bus.cdb_data; end
          if (!mq[i].rtv && mq[i].rt == bus.cdb_tag) begin mq[i].rtv = 1; mq[i].rtd = bus.cdb_data; end
        end
      end
      if (bus.dispatch_en && pre_ready) begin
        if (bypass && bus.cdb_valid) begin
          if (!ne.rsv && ne.rs == bus.cdb_tag) begin ne.rsv = 1; ne.rsd = bus.cdb_data; end
          if (!ne.rtv && ne.rt == bus.cdb_tag) begin ne.rtv = 1; ne.rtd = bus.cdb_data; end
        end
        mq.push_back(ne);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/equeueint.md
EQUEUEINT -- requirements
Module: equeueint

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries (2..16).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 dispatch_opcode  in  4  integer ALU opcode of the dispatched instruction.
REQ-005 dispatch_en  in  1  dispatch request, one instruction per cycle.
REQ-006 dispatch_ready  out  1  queue can accept a dispatch this cycle.
REQ-007 dispatch_rdtag / dispatch_rstag / dispatch_rttag  in  6 each  destination and source rename tags.
REQ-008 dispatch_rsdata / dispatch_rtdata  in  32 each  source operand values.
REQ-009 dispatch_rsvalid / dispatch_rtvalid  in  1 each  operand value present; when 0 the operand waits on its tag.
REQ-010 cdb_tag  in  6, cdb_valid  in  1, cdb_data  in  32  common data bus broadcast.
REQ-011 issueint_opcode  out  4, issueint_rdtag  out  6, issueint_rsdata  out  32, issueint_rtdata  out  32  selected entry.
REQ-012 issueint_ready  out  1  a selected entry with both operands valid exists.
REQ-013 issueint_done  in  1  issue unit consumed the presented entry this cycle.

Function
REQ-014 Entries SHALL be age-ordered; index 0 oldest, valid entries contiguous from 0.
REQ-015 Each entry SHALL hold valid, opcode, rdtag, rstag, rttag, rsdata, rtdata, rsvalid, rtvalid.
REQ-016 dispatch_ready SHALL be 1 iff fewer than DEPTH entries are valid (registered state only, no same-cycle done credit).
REQ-017 dispatch_en with dispatch_ready=1 SHALL write the first free slot after removal of any entry issued that edge; dispatch_en with dispatch_ready=0 SHALL be ignored.
REQ-018 Selection SHALL be the oldest valid entry with rsvalid and rtvalid both 1; issueint_ready and issueint_* outputs SHALL be combinational from that entry.
REQ-019 With no selectable entry, issueint_ready=0 and issueint_opcode/rdtag/rsdata/rtdata SHALL be 0.
REQ-020 issueint_done=1 with issueint_ready=1 SHALL remove the selected entry at the edge; younger entries SHALL shift down one slot, preserving order; issueint_done with issueint_ready=0 SHALL be ignored.
REQ-021 CDB capture: with cdb_valid=1, every valid entry with rsvalid=0 and rstag==cdb_tag SHALL load rsdata=cdb_data, rsvalid=1 (same for rt); both operands MAY capture in one cycle; capture SHALL apply to the entry's post-shift position.
REQ-022 A captured entry SHALL be selectable no earlier than the cycle after capture.
REQ-023 Simultaneous dispatch, done and CDB capture SHALL all take effect at the same edge without loss.
REQ-024 Tags SHALL be compared over all 6 bits; no wrap or tag aging logic.

Reset
REQ-025 reset=1 SHALL immediately clear all entry valid bits and fields to 0.
REQ-026 During and after reset: dispatch_ready=1, issueint_ready=0, issueint_* data outputs 0.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries and any in-flight capture.

Configuration
REQ-028 Macro EQUEUEINT_CDB_BYPASS_EN defined: a dispatch whose operand valid=0 and tag equals cdb_tag with cdb_valid=1 in the same cycle SHALL store cdb_data with valid=1.
REQ-029 Macro EQUEUEINT_CDB_BYPASS_EN undefined: such an operand SHALL be stored not-valid and wait for a later broadcast.

Verification
REQ-030 Reset then dispatch opcode 0, rdtag 1, rstag 2, rttag 3, rsdata 2, rtdata 2, both valid -> next cycle issueint_ready=1, rdtag 1, rsdata 2, rtdata 2, opcode 0; done -> following cycle issueint_ready=0.
REQ-031 Dispatch rsvalid=0 rstag 5, then cdb_valid=1 tag 5 data 0x1234 -> issueint_ready=1 next cycle with rsdata 0x1234.
REQ-032 DEPTH dispatches without done -> dispatch_ready=0, extra dispatch_en ignored; one done -> dispatch_ready=1 next cycle.
REQ-033 Entry 0 waiting, entry 1 ready -> entry 1 presented; done removes it and entry 0 stays at index 0.
REQ-034 Dispatch with rsvalid=0 tag 7 concurrent with CDB tag 7 data 0xAA -> ready next cycle with macro defined; waits without it.
REQ-035 Assert reset with 3 entries queued -> dispatch_ready=1, issueint_ready=0 immediately, before next clock edge.
